// File: rtl/regfile_onehot_wr_if.sv
// Bus bundle for regfile_onehot_wr: one-hot write port, two read ports, status outputs.
// master drives the write/read requests; slave is the register file itself.
interface regfile_onehot_wr_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic [31:0]           wr_onehot;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  err_clr;
    logic [4:0]            rd_sel_a;
    logic [4:0]            rd_sel_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  wr_err;
    logic [4:0]            last_wr_idx;
    logic [15:0]           wr_count;

    modport master (
        output wr_en, wr_onehot, wr_data, err_clr, rd_sel_a, rd_sel_b,
        input  rd_data_a, rd_data_b, wr_err, last_wr_idx, wr_count
    );

    modport slave (
        input  wr_en, wr_onehot, wr_data, err_clr, rd_sel_a, rd_sel_b,
        output rd_data_a, rd_data_b, wr_err, last_wr_idx, wr_count
    );
endinterface

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file with a one-hot write select, sticky malformed-write flag and write stats.
// Define REGFILE_BYPASS_EN to forward a pending valid write to the read ports in the same cycle.
module regfile_onehot_wr #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    regfile_onehot_wr_if.slave  bus
);

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] regs_d [32];
    logic                  wr_err_q, wr_err_d;
    logic [4:0]            last_wr_idx_q, last_wr_idx_d;
    logic [15:0]           wr_count_q, wr_count_d;

    logic                  is_onehot;
    logic                  wr_valid;
    logic                  wr_bad;
    logic [4:0]            wr_idx;
    logic [DATA_WIDTH-1:0] rd_a_mux;
    logic [DATA_WIDTH-1:0] rd_b_mux;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    always_comb begin
        is_onehot = (bus.wr_onehot != 32'd0) &&
                    ((bus.wr_onehot & (bus.wr_onehot - 32'd1)) == 32'd0);
        wr_valid  = bus.wr_en && is_onehot;
        wr_bad    = bus.wr_en && !is_onehot;
        wr_idx    = 5'd0;
        for (int k = 0; k < 32; k++) begin
            if (bus.wr_onehot[k]) begin
                wr_idx = k[4:0];
            end
        end
    end

    always_comb begin
        regs_d        = regs_q;
        wr_err_d      = wr_err_q;
        last_wr_idx_d = last_wr_idx_q;
        wr_count_d    = wr_count_q;
        if (wr_valid) begin
            if (wr_idx != 5'd0) begin
                regs_d[wr_idx] = bus.wr_data;
            end
            last_wr_idx_d = wr_idx;
            wr_count_d    = wr_count_q + 16'd1;
        end
        // A malformed write in the same cycle as a clear leaves the flag set.
        if (bus.err_clr) begin
            wr_err_d = 1'b0;
        end
        if (wr_bad) begin
            wr_err_d = 1'b1;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < 32; k++) begin
                regs_q[k] <= '0;
            end
            wr_err_q      <= 1'b0;
            last_wr_idx_q <= 5'd0;
            wr_count_q    <= 16'd0;
        end else begin
            regs_q        <= regs_d;
            wr_err_q      <= wr_err_d;
            last_wr_idx_q <= last_wr_idx_d;
            wr_count_q    <= wr_count_d;
        end
    end

    always_comb begin
        rd_a_mux = (bus.rd_sel_a == 5'd0) ? '0 : regs_q[bus.rd_sel_a];
        rd_b_mux = (bus.rd_sel_b == 5'd0) ? '0 : regs_q[bus.rd_sel_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (wr_idx != 5'd0) && (bus.rd_sel_a == wr_idx)) begin
            rd_a_mux = bus.wr_data;
        end
        if (wr_valid && (wr_idx != 5'd0) && (bus.rd_sel_b == wr_idx)) begin
            rd_b_mux = bus.wr_data;
        end
`endif
    end

    assign bus.rd_data_a   = rd_a_mux;
    assign bus.rd_data_b   = rd_b_mux;
    assign bus.wr_err      = wr_err_q;
    assign bus.last_wr_idx = last_wr_idx_q;
    assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Randomized self-checking bench for regfile_onehot_wr against an array-based reference model.
// Follows REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_onehot_wr;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    regfile_onehot_wr_if #(.DATA_WIDTH(32)) bus ();

    regfile_onehot_wr #(.DATA_WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_err;
    logic [4:0]  m_last;
    logic [15:0] m_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en;
    logic [31:0] pre_a;
    logic [31:0] saved;
    logic [15:0] cnt_saved;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && $countones(bus.wr_onehot) == 1 && bus.wr_onehot[s]) return bus.wr_data;
`endif
        return m_regs[s];
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
            m_err  = 1'b0;
            m_last = 5'd0;
            m_cnt  = 16'd0;
        end else begin
            if (bus.err_clr) m_err = 1'b0;
            if (bus.wr_en) begin
                if ($countones(bus.wr_onehot) == 1) begin
                    m_last = 5'($clog2(bus.wr_onehot));
                    if (m_last != 5'd0) m_regs[m_last] = bus.wr_data;
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle from the falling edge: check reads before the edge, then state after it.
    task automatic cycle(input logic rn, input logic we, input logic [31:0] oh,
                         input logic [31:0] d, input logic ec,
                         input logic [4:0] sa, input logic [4:0] sb);
        reset_n       = rn;
        bus.wr_en     = we;
        bus.wr_onehot = oh;
        bus.wr_data   = d;
        bus.err_clr   = ec;
        bus.rd_sel_a  = sa;
        bus.rd_sel_b  = sb;
        #1;
        pre_a = bus.rd_data_a;
        if (chk_en) begin
            chk("rd_a_pre", bus.rd_data_a, exp_rd(sa));
            chk("rd_b_pre", bus.rd_data_b, exp_rd(sb));
        end
        @(posedge clock);
        model_edge();
        #1;
        if (chk_en) begin
            chk("wr_err", bus.wr_err, m_err);
            chk("last_wr_idx", bus.last_wr_idx, m_last);
            chk("wr_count", bus.wr_count, m_cnt);
            chk("rd_a_post", bus.rd_data_a, exp_rd(sa));
            chk("rd_b_post", bus.rd_data_b, exp_rd(sb));
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic [4:0] sa, input logic [4:0] sb);
        cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, sa, sb);
    endtask

    initial begin
        logic [31:0] oh;
        logic [4:0]  r;
        chk_en = 1'b0;
        @(negedge clock);

        // Reset for two cycles, then every register and status output reads zero.
        cycle(1'b0, 1'b1, 32'd8, 32'hFFFF_FFFF, 1'b0, 5'd3, 5'd0);
        chk_en = 1'b1;
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd1);
        chk("rst_err", bus.wr_err, 1'b0);
        chk("rst_last", bus.last_wr_idx, 5'd0);
        chk("rst_cnt", bus.wr_count, 16'd0);
        for (int i = 0; i < 32; i += 2) begin
            idle(5'(i), 5'(i + 1));
            chk("rst_rd_a", bus.rd_data_a, 32'd0);
            chk("rst_rd_b", bus.rd_data_b, 32'd0);
        end

        // Walk every register with its own pattern.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b1, 32'd1 << i, 32'hA5A5_0000 + 32'(i), 1'b0, 5'(i), 5'd0);
        end
        chk("walk_cnt", bus.wr_count, 16'd32);
        chk("walk_last", bus.last_wr_idx, 5'd31);
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'((i + 1) % 32));
            chk("walk_rd", bus.rd_data_a, (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i));
        end

        // Malformed vectors leave the file and counters alone and set the sticky flag.
        cycle(1'b1, 1'b1, 32'h20, 32'h1234, 1'b0, 5'd5, 5'd4);
        cnt_saved = bus.wr_count;
        cycle(1'b1, 1'b1, 32'h30, 32'hBAD0_0001, 1'b0, 5'd5, 5'd4);
        chk("mal_err", bus.wr_err, 1'b1);
        chk("mal_rd5", bus.rd_data_a, 32'h1234);
        chk("mal_rd4", bus.rd_data_b, 32'hA5A5_0004);
        cycle(1'b1, 1'b1, 32'h0, 32'hBAD0_0002, 1'b0, 5'd5, 5'd0);
        chk("mal0_cnt", bus.wr_count, cnt_saved);
        chk("mal0_last", bus.last_wr_idx, 5'd5);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd0);
        chk("clr_err", bus.wr_err, 1'b0);
        cycle(1'b1, 1'b1, 32'h8000_0001, 32'h0, 1'b1, 5'd31, 5'd0);
        chk("clr_set_err", bus.wr_err, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd0);

        // Idle cycles ignore the select vector entirely.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 5'd9, 5'd5);
            chk("idle_err", bus.wr_err, 1'b0);
            chk("idle_rd9", bus.rd_data_a, 32'hA5A5_0009);
        end

        // Same-cycle read of the register being written.
        saved = m_regs[7];
        cycle(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 1'b0, 5'd7, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("byp_pre", pre_a, 32'hDEAD_BEEF);
`else
        chk("byp_pre", pre_a, saved);
`endif
        idle(5'd7, 5'd7);
        chk("byp_post", bus.rd_data_a, 32'hDEAD_BEEF);

        // Random mix of valid, malformed, idle, clear and occasional reset cycles.
        for (int n = 0; n < 2000; n++) begin
            r = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0, 1:    oh = 32'd1 << r;
                2:       oh = 32'd0;
                default: oh = $urandom;
            endcase
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), oh, $urandom,
                  ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Counter wrap, then reset beats a concurrent write.
        while (m_cnt != 16'hFFFF) begin
            r = 5'($urandom_range(0, 31));
            cycle(1'b1, 1'b1, 32'd1 << r, $urandom, 1'b0, 5'($urandom_range(0, 31)), r);
        end
        chk("pre_wrap", bus.wr_count, 16'hFFFF);
        cycle(1'b1, 1'b1, 32'd1 << 3, 32'h0000_3333, 1'b0, 5'd3, 5'd0);
        chk("wrap_cnt", bus.wr_count, 16'd0);
        chk("wrap_rd3", bus.rd_data_a, 32'h0000_3333);
        cycle(1'b0, 1'b1, 32'd1 << 3, 32'h7777_7777, 1'b0, 5'd2, 5'd0);
        idle(5'd3, 5'd0);
        chk("rstwr_rd3", bus.rd_data_a, 32'd0);
        chk("rstwr_cnt", bus.wr_count, 16'd0);
        chk("rstwr_last", bus.last_wr_idx, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
